fetch_ctrl: RTL and testbench

Sequences the instruction-fetch stage: drives the PC register's stall/select/branch-target controls and runs a single-outstanding req/gnt/rvalid handshake to a variable-latency instruction memory. Delivers fetched instructions to decode through a registered valid/stall interface. Applies branch redirects from EX, including redirects that arrive while a fetch is in flight.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_outbuf.sv | 84 ++++++++
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    KILL = 3'd4
  } fetch_state_e;

  // Canonical RISC-V NOP (addi x0, x0, 0).
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_outbuf.sv
// Output register to decode plus a 1-entry hold buffer that catches a
// response arriving while decode is stalled on a full output register.
module fetch_outbuf
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_instr_i,
  input  logic [WIDTH-1:0] push_pc_i,
  input  logic             dec_stall_i,
  output logic             out_free_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [WIDTH-1:0] hold_pc_q, hold_pc_d;

  // The output slot can take new data when empty or being consumed now.
  assign out_free_o = !valid_q || !dec_stall_i;
  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;

  // Next-state: flush wins, then drain hold buffer, then accept a push.
  always_comb begin
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (flush_i) begin
      valid_d      = 1'b0;
      hold_valid_d = 1'b0;
    end else if (out_free_o) begin
      if (hold_valid_q) begin
        valid_d      = 1'b1;
        instr_d      = hold_instr_q;
        pc_d         = hold_pc_q;
        hold_valid_d = 1'b0;
      end else if (push_i) begin
        valid_d = 1'b1;
        instr_d = push_instr_i;
        pc_d    = push_pc_i;
      end else begin
        valid_d = 1'b0;
      end
    end else if (push_i) begin
      hold_valid_d = 1'b1;
      hold_instr_d = push_instr_i;
      hold_pc_d    = push_pc_i;
    end
  end

  // Register update with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      instr_q      <= '0;
      pc_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: single-outstanding req/gnt/rvalid handshake,
// PC register control, and branch redirects including in-flight kills.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pc_current_in,
  output logic             stall_out,
  output logic             pc_src_out,
  output logic [WIDTH-1:0] pc_branch_out,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_gnt_in,
  input  logic             imem_rvalid_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic             if_valid_out,
  output logic [WIDTH-1:0] if_instr_out,
  output logic [WIDTH-1:0] if_pc_out,
  input  logic             dec_stall_in
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             out_free;
  logic             push;
  logic             flush;

  // The PC register is held while a fetch is outstanding, so the current PC
  // is both the request address and the PC of the returning instruction.
  assign imem_req_out  = (state_q == REQ);
  assign imem_addr_out = pc_current_in;
  assign pc_branch_out = redirect_in ? redirect_pc_in : pend_q;

  // Any redirect squashes younger instructions waiting for decode.
  assign flush = redirect_in;

  // FSM next-state and PC-control decode.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    stall_out  = 1'b1;
    pc_src_out = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_in) begin
          stall_out  = 1'b0;
          pc_src_out = 1'b1;
        end
      end
      REQ: begin
        if (imem_gnt_in) begin
          if (redirect_in) begin
            pend_d  = redirect_pc_in;
            state_d = KILL;
          end else begin
            state_d = WAIT;
          end
        end else if (redirect_in) begin
          stall_out  = 1'b0;
          pc_src_out = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_in && imem_rvalid_in) begin
          stall_out  = 1'b0;
          pc_src_out = 1'b1;
          state_d    = REQ;
        end else if (redirect_in) begin
          pend_d  = redirect_pc_in;
          state_d = KILL;
        end else if (imem_rvalid_in) begin
          push = 1'b1;
          if (out_free) begin
            stall_out = 1'b0;
            state_d   = REQ;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_in) begin
          stall_out  = 1'b0;
          pc_src_out = 1'b1;
          state_d    = REQ;
        end else if (out_free) begin
          stall_out = 1'b0;
          state_d   = REQ;
        end
      end
      KILL: begin
        if (redirect_in) begin
          pend_d = redirect_pc_in;
        end
        if (imem_rvalid_in) begin
          stall_out  = 1'b0;
          pc_src_out = 1'b1;
          state_d    = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  fetch_outbuf #(
    .WIDTH(WIDTH)
  ) u_outbuf (
    .clk_i       (clk_in),
    .rst_ni      (rst_in),
    .flush_i     (flush),
    .push_i      (push),
    .push_instr_i(imem_rdata_in),
    .push_pc_i   (pc_current_in),
    .dec_stall_i (dec_stall_in),
    .out_free_o  (out_free),
    .valid_o     (if_valid_out),
    .instr_o     (if_instr_out),
    .pc_o        (if_pc_out)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle vector table for streaming
// and decode back-pressure, hand sequences for redirect and reset corners,
// and a scoreboard of instructions expected at decode.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rstN;
  logic [31:0] pcCurrent;
  logic        stallOut;
  logic        pcSrcOut;
  logic [31:0] pcBranchOut;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic        ifValid;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        decStall;

  logic [31:0] pcReg;
  logic        seen200;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t expQ[$];

  typedef struct {
    logic        rstV;
    logic        gntV;
    logic        rvalidV;
    logic [31:0] rdataV;
    logic        decStallV;
    logic        deliver;
    logic [31:0] pushPc;
    logic        expStall;
    logic        expSrc;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
  } vec_t;

  always #5 clk = ~clk;

  // PC register of the IF stage, steered by the controller.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) pcReg <= 32'h0;
    else if (!stallOut) pcReg <= pcSrcOut ? pcBranchOut : pcReg + 32'd4;
  end
  assign pcCurrent = pcReg;

  fetch_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_in        (clk),
    .rst_in        (rstN),
    .pc_current_in (pcCurrent),
    .stall_out     (stallOut),
    .pc_src_out    (pcSrcOut),
    .pc_branch_out (pcBranchOut),
    .redirect_in   (redirect),
    .redirect_pc_in(redirectPc),
    .imem_req_out  (imemReq),
    .imem_addr_out (imemAddr),
    .imem_gnt_in   (imemGnt),
    .imem_rvalid_in(imemRvalid),
    .imem_rdata_in (imemRdata),
    .if_valid_out  (ifValid),
    .if_instr_out  (ifInstr),
    .if_pc_out     (ifPc),
    .dec_stall_in  (decStall)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the clock edge, then let them settle.
  task automatic applyStimulus(input logic rstV, input logic gntV, input logic rvalidV,
                               input logic [31:0] rdataV, input logic redirV,
                               input logic [31:0] redirPcV, input logic decStallV);
    @(posedge clk);
    #1;
    rstN       = rstV;
    imemGnt    = gntV;
    imemRvalid = rvalidV;
    imemRdata  = rdataV;
    redirect   = redirV;
    redirectPc = redirPcV;
    decStall   = decStallV;
    #1;
  endtask

  // Scoreboard: an entry consumed by decode this cycle must match the queue head.
  task automatic monitorCycle();
    exp_t e;
    if (imemReq && imemGnt && imemAddr == 32'h200) seen200 = 1'b1;
    if (ifValid && !decStall) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got instr %h pc %h, expected no delivery", ifInstr, ifPc);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_instr", ifInstr, e.instr);
        checkOutput("sb_pc", ifPc, e.pc);
      end
    end
  endtask

  function automatic vec_t mk(input logic r, input logic g, input logic rv,
                              input logic [31:0] rd, input logic ds, input logic dl,
                              input logic [31:0] pp, input logic es, input logic esrc,
                              input logic erq, input logic [31:0] ea, input logic ev);
    vec_t v;
    v.rstV = r; v.gntV = g; v.rvalidV = rv; v.rdataV = rd; v.decStallV = ds;
    v.deliver = dl; v.pushPc = pp; v.expStall = es; v.expSrc = esrc;
    v.expReq = erq; v.expAddr = ea; v.expValid = ev;
    return v;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[11];
    localparam logic [31:0] I1 = 32'h0050_0093;
    localparam logic [31:0] I2 = 32'h0010_0113;

    rstN = 1'b0; imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    redirect = 1'b0; redirectPc = '0; decStall = 1'b0; seen200 = 1'b0;

    //             rst gnt rv rdata ds dl pushPc  stall src req addr  valid
    vecs[0]  = mk(0, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0,     0);
    vecs[1]  = mk(1, 0, 0, 0,  0, 0, 0,     1, 0, 0, 0,     0);
    vecs[2]  = mk(1, 1, 0, 0,  0, 0, 0,     1, 0, 1, 32'h0, 0);
    vecs[3]  = mk(1, 0, 1, I1, 0, 1, 32'h0, 0, 0, 0, 0,     0);
    vecs[4]  = mk(1, 1, 0, 0,  1, 0, 0,     1, 0, 1, 32'h4, 1);
    vecs[5]  = mk(1, 0, 1, I2, 1, 1, 32'h4, 1, 0, 0, 0,     1);
    vecs[6]  = mk(1, 0, 0, 0,  1, 0, 0,     1, 0, 0, 0,     1);
    vecs[7]  = mk(1, 0, 0, 0,  0, 0, 0,     0, 0, 0, 0,     1);
    vecs[8]  = mk(1, 0, 0, 0,  0, 0, 0,     1, 0, 1, 32'h8, 1);
    vecs[9]  = mk(1, 0, 0, 0,  0, 0, 0,     1, 0, 1, 32'h8, 0);
    vecs[10] = mk(1, 1, 0, 0,  0, 0, 0,     1, 0, 1, 32'h8, 0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rstV, vecs[i].gntV, vecs[i].rvalidV, vecs[i].rdataV,
                    1'b0, 32'h0, vecs[i].decStallV);
      if (vecs[i].deliver) expQ.push_back('{pc: vecs[i].pushPc, instr: vecs[i].rdataV});
      checkOutput($sformatf("v%0d_stall", i), {31'b0, stallOut}, {31'b0, vecs[i].expStall});
      checkOutput($sformatf("v%0d_pcsrc", i), {31'b0, pcSrcOut}, {31'b0, vecs[i].expSrc});
      checkOutput($sformatf("v%0d_req", i), {31'b0, imemReq}, {31'b0, vecs[i].expReq});
      checkOutput($sformatf("v%0d_valid", i), {31'b0, ifValid}, {31'b0, vecs[i].expValid});
      if (vecs[i].expReq) checkOutput($sformatf("v%0d_addr", i), imemAddr, vecs[i].expAddr);
      if (!vecs[i].rstV) begin
        checkOutput("rst_instr", ifInstr, 32'h0);
        checkOutput("rst_pc", ifPc, 32'h0);
        checkOutput("rst_branch", pcBranchOut, 32'h0);
      end
      monitorCycle();
    end

    // Redirect while waiting: response must be discarded, target taken on rvalid.
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h100, 0);
    checkOutput("wk_stall", {31'b0, stallOut}, 32'd1);
    checkOutput("wk_req", {31'b0, imemReq}, 32'd0);
    monitorCycle();
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("kill_stall", {31'b0, stallOut}, 32'd1);
    checkOutput("kill_branch", pcBranchOut, 32'h100);
    checkOutput("kill_valid", {31'b0, ifValid}, 32'd0);
    monitorCycle();
    applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    checkOutput("kdrop_stall", {31'b0, stallOut}, 32'd0);
    checkOutput("kdrop_pcsrc", {31'b0, pcSrcOut}, 32'd1);
    checkOutput("kdrop_branch", pcBranchOut, 32'h100);
    monitorCycle();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("after_kill_addr", imemAddr, 32'h100);
    checkOutput("after_kill_valid", {31'b0, ifValid}, 32'd0);
    monitorCycle();

    // Two redirects during one kill window: only the later target is used.
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h200, 0);
    checkOutput("r200_stall", {31'b0, stallOut}, 32'd1);
    monitorCycle();
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h300, 0);
    checkOutput("r300_stall", {31'b0, stallOut}, 32'd1);
    checkOutput("r300_branch", pcBranchOut, 32'h300);
    monitorCycle();
    applyStimulus(1, 0, 1, 32'h0BAD_F00D, 0, 32'h0, 0);
    checkOutput("k300_pcsrc", {31'b0, pcSrcOut}, 32'd1);
    checkOutput("k300_branch", pcBranchOut, 32'h300);
    monitorCycle();

    // Redirect in REQ while the grant is withheld, then redirect with rvalid.
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h400, 0);
    checkOutput("rq_addr_old", imemAddr, 32'h300);
    checkOutput("rq_stall", {31'b0, stallOut}, 32'd0);
    checkOutput("rq_pcsrc", {31'b0, pcSrcOut}, 32'd1);
    checkOutput("rq_branch", pcBranchOut, 32'h400);
    monitorCycle();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
      checkOutput($sformatf("rq_wait%0d_addr", k), imemAddr, 32'h400);
      checkOutput($sformatf("rq_wait%0d_stall", k), {31'b0, stallOut}, 32'd1);
      monitorCycle();
    end
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rq_gnt_addr", imemAddr, 32'h400);
    monitorCycle();
    applyStimulus(1, 0, 1, 32'h1234_5678, 1, 32'h500, 0);
    checkOutput("rr_stall", {31'b0, stallOut}, 32'd0);
    checkOutput("rr_pcsrc", {31'b0, pcSrcOut}, 32'd1);
    checkOutput("rr_branch", pcBranchOut, 32'h500);
    monitorCycle();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rr_addr", imemAddr, 32'h500);
    checkOutput("rr_valid", {31'b0, ifValid}, 32'd0);
    monitorCycle();
    applyStimulus(1, 0, 1, NOP, 0, 32'h0, 0);
    expQ.push_back('{pc: 32'h500, instr: NOP});
    checkOutput("nop_stall", {31'b0, stallOut}, 32'd0);
    monitorCycle();
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("nop_valid", {31'b0, ifValid}, 32'd1);
    checkOutput("nop_addr", imemAddr, 32'h504);
    monitorCycle();

    // Asynchronous reset while a fetch is in flight.
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("mrst_stall", {31'b0, stallOut}, 32'd1);
    checkOutput("mrst_pcsrc", {31'b0, pcSrcOut}, 32'd0);
    checkOutput("mrst_req", {31'b0, imemReq}, 32'd0);
    checkOutput("mrst_valid", {31'b0, ifValid}, 32'd0);
    checkOutput("mrst_instr", ifInstr, 32'h0);
    checkOutput("mrst_pc", ifPc, 32'h0);
    checkOutput("mrst_branch", pcBranchOut, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("mrst_idle_req", {31'b0, imemReq}, 32'd0);
    checkOutput("mrst_idle_stall", {31'b0, stallOut}, 32'd1);
    monitorCycle();
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("mrst_req_again", {31'b0, imemReq}, 32'd1);
    checkOutput("mrst_addr", imemAddr, 32'h0);
    monitorCycle();

    checkOutput("sb_drained", expQ.size(), 32'd0);
    checkOutput("never_fetched_200", {31'b0, seen200}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
